// File: rtl/id_ex_stage_if.sv
// rtl/id_ex_stage_if.sv - fetch, register-file and execute-side signals of the ID/EX stage
interface id_ex_stage_if;
    logic        if_valid;
    logic [15:0] if_instr;
    logic        if_ready;
    logic [3:0]  rf_raddr1;
    logic [3:0]  rf_raddr2;
    logic [15:0] rf_rdata1;
    logic [15:0] rf_rdata2;
    logic        ex_stall;
    logic        flush;
    logic        ex_valid;
    logic [3:0]  ex_opcode;
    logic [15:0] ex_A;
    logic [15:0] ex_B;
    logic [7:0]  ex_I;
    logic [3:0]  ex_rd;
    logic        ex_wr_en;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic        halted;

    modport master (
        output if_valid, if_instr, rf_rdata1, rf_rdata2, ex_stall, flush,
        input  if_ready, rf_raddr1, rf_raddr2, ex_valid, ex_opcode, ex_A, ex_B,
               ex_I, ex_rd, ex_wr_en, ex_mem_rd, ex_mem_wr, halted
    );

    modport slave (
        input  if_valid, if_instr, rf_rdata1, rf_rdata2, ex_stall, flush,
        output if_ready, rf_raddr1, rf_raddr2, ex_valid, ex_opcode, ex_A, ex_B,
               ex_I, ex_rd, ex_wr_en, ex_mem_rd, ex_mem_wr, halted
    );
endinterface

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - instruction decode and ID/EX register feeding the 16-bit ALU
module id_ex_stage (
    input logic          clk,
    input logic          rst_n,
    id_ex_stage_if.slave bus
);
    localparam logic [3:0] OP_LW  = 4'b1000;
    localparam logic [3:0] OP_SW  = 4'b1001;
    localparam logic [3:0] OP_PCS = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t state_q, state_d;

    logic [3:0] opcode, fld_rd, fld_rs, fld_rt;
    logic [3:0] dec_raddr1, dec_raddr2;
    logic [7:0] dec_imm;
    logic       dec_wr_en, dec_mem_rd, dec_mem_wr, dec_use_raddr2;
    logic       hazard, ready, transfer, halted;

    logic        ex_valid_q;
    logic [3:0]  ex_opcode_q;
    logic [15:0] ex_a_q, ex_b_q;
    logic [7:0]  ex_i_q;
    logic [3:0]  ex_rd_q;
    logic        ex_wr_en_q, ex_mem_rd_q, ex_mem_wr_q;

    assign opcode = bus.if_instr[15:12];
    assign fld_rd = bus.if_instr[11:8];
    assign fld_rs = bus.if_instr[7:4];
    assign fld_rt = bus.if_instr[3:0];

    always_comb begin
        dec_raddr1     = fld_rs;
        dec_raddr2     = 4'd0;
        dec_imm        = 8'd0;
        dec_wr_en      = 1'b1;
        dec_mem_rd     = 1'b0;
        dec_mem_wr     = 1'b0;
        dec_use_raddr2 = 1'b0;
        case (opcode)
            4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0111: begin
                dec_raddr2     = fld_rt;
                dec_use_raddr2 = 1'b1;
            end
            4'b0100, 4'b0101, 4'b0110: begin
                dec_imm = {4'b0000, fld_rt};
            end
            OP_LW: begin
                dec_imm    = {{4{fld_rt[3]}}, fld_rt};
                dec_mem_rd = 1'b1;
            end
            // SW reads rd on port 2 so the store data rides on ex_B
            OP_SW: begin
                dec_raddr2     = fld_rd;
                dec_imm        = {{4{fld_rt[3]}}, fld_rt};
                dec_wr_en      = 1'b0;
                dec_mem_wr     = 1'b1;
                dec_use_raddr2 = 1'b1;
            end
            4'b1010, 4'b1011: begin
                dec_raddr1 = fld_rd;
                dec_imm    = bus.if_instr[7:0];
            end
            4'b1100, 4'b1101, OP_PCS: begin
                dec_imm   = bus.if_instr[7:0];
                dec_wr_en = (opcode == OP_PCS);
            end
            default: begin
                dec_raddr1 = 4'd0;
                dec_wr_en  = 1'b0;
            end
        endcase
    end

    // The loaded value only exists after execute's memory access, so stall one cycle
    always_comb begin
        hazard = 1'b0;
        if (ex_valid_q && ex_mem_rd_q && (ex_rd_q != 4'd0)) begin
            hazard = (ex_rd_q == dec_raddr1) ||
                     (dec_use_raddr2 && (ex_rd_q == dec_raddr2));
        end
    end

    assign ready    = !halted && !bus.ex_stall && !hazard && !bus.flush;
    assign transfer = bus.if_valid && ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // transfer is already blocked by flush, so a flushed HLT never halts
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:  if (transfer && (opcode == OP_HLT)) state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_RUN;
        endcase
    end

    always_comb begin
        halted = 1'b0;
        case (state_q)
            ST_HALT: halted = 1'b1;
            default: halted = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q  <= 1'b0;
            ex_opcode_q <= 4'd0;
            ex_a_q      <= 16'd0;
            ex_b_q      <= 16'd0;
            ex_i_q      <= 8'd0;
            ex_rd_q     <= 4'd0;
            ex_wr_en_q  <= 1'b0;
            ex_mem_rd_q <= 1'b0;
            ex_mem_wr_q <= 1'b0;
        end else if (bus.flush) begin
            ex_valid_q <= 1'b0;
        end else if (!bus.ex_stall) begin
            if (transfer) begin
                ex_valid_q  <= 1'b1;
                ex_opcode_q <= opcode;
                ex_a_q      <= bus.rf_rdata1;
                ex_b_q      <= bus.rf_rdata2;
                ex_i_q      <= dec_imm;
                ex_rd_q     <= fld_rd;
                ex_wr_en_q  <= dec_wr_en;
                ex_mem_rd_q <= dec_mem_rd;
                ex_mem_wr_q <= dec_mem_wr;
            end else begin
                ex_valid_q <= 1'b0;
            end
        end
    end

    assign bus.if_ready  = ready;
    assign bus.rf_raddr1 = dec_raddr1;
    assign bus.rf_raddr2 = dec_raddr2;
    assign bus.ex_valid  = ex_valid_q;
    assign bus.ex_opcode = ex_opcode_q;
    assign bus.ex_A      = ex_a_q;
    assign bus.ex_B      = ex_b_q;
    assign bus.ex_I      = ex_i_q;
    assign bus.ex_rd     = ex_rd_q;
    assign bus.ex_wr_en  = ex_wr_en_q;
    assign bus.ex_mem_rd = ex_mem_rd_q;
    assign bus.ex_mem_wr = ex_mem_wr_q;
    assign bus.halted    = halted;
endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Decode stage and ID/EX pipeline register that produces the operand bundle consumed by the 16-bit ALU. It sits between fetch and execute and accepts one instruction word per handshake. It reads two register-file ports and decodes the opcode into ALU opcode, A, B, 8-bit immediate and control flags, then registers them for execute. It also inserts load-use bubbles, honours execute backpressure and branch flushes, and latches HLT.

## Interface
Parameters: none (datapath fixed at 16 bits, 16 registers).
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- if_valid  in  1  fetch presents instruction
- if_instr  in  16  instruction word: opcode [15:12], rd [11:8], rs [7:4], rt [3:0]
- if_ready  out  1  stage accepts if_instr this cycle
- rf_raddr1  out  4  register-file read address feeding A
- rf_raddr2  out  4  register-file read address feeding B
- rf_rdata1  in  16  combinational read data, port 1 (register file bypasses same-cycle writes)
- rf_rdata2  in  16  combinational read data, port 2
- ex_stall  in  1  execute cannot accept; hold output register
- flush  in  1  branch taken; kill instruction in the ID/EX register and the one on if_instr
- ex_valid  out  1  output register holds a live instruction
- ex_opcode  out  4  ALU opcode
- ex_A  out  16  ALU A operand
- ex_B  out  16  ALU B operand; store data for SW
- ex_I  out  8  ALU immediate
- ex_rd  out  4  destination register
- ex_wr_en  out  1  instruction writes ex_rd
- ex_mem_rd  out  1  LW
- ex_mem_wr  out  1  SW
- halted  out  1  HLT has issued

## Operation
Field decode (combinational on if_instr):
- 0000–0011, 0111 (ADD/SUB/XOR/RED/PADDSB): raddr1=rs, raddr2=rt, I=0, wr_en=1.
- 0100–0110 (SLL/SRA/ROR): raddr1=rs, raddr2=0, I={4'b0,instr[3:0]}, wr_en=1.
- 1000 LW: raddr1=rs, I={{4{instr[3]}},instr[3:0]}, wr_en=1, mem_rd=1.
- 1001 SW: raddr1=rs, raddr2=rd, I as LW, wr_en=0, mem_wr=1. ex_B carries the store data.
- 1010 LLB / 1011 LHB: raddr1=rd, I=instr[7:0], wr_en=1.
- 1100–1110 (B/BR/PCS): raddr1=rs, I=instr[7:0], wr_en=(opcode==1110). The branch unit consumes ex_I; the ALU result is ignored.
- 1111 HLT: wr_en=0, all flags 0. Setting ex_opcode=1111 is legal; the ALU result is ignored.
- The stage feeds ex_A from rf_rdata1 and ex_B from rf_rdata2 unmodified. EX-to-ID forwarding is done in execute.

Hazard and handshake:
- A load-use hazard exists when ex_valid & ex_mem_rd & ex_rd != 0 and ex_rd equals a used source address (raddr1, or raddr2 for R-type and SW).
- if_ready = !halted & !ex_stall & !hazard.
- A transfer occurs when if_valid & if_ready.
- The ID/EX register loads on transfer. On hazard with !ex_stall it loads a bubble (ex_valid=0). When there is no transfer and no stall it also loads ex_valid=0. On ex_stall it holds every field.
- flush (priority over everything except reset): clears ex_valid next edge and drops the current if_instr. if_ready=0 during flush.

State machine for halted:
- RUN -> HALT on transfer of opcode 1111. HALT is sticky until rst_n.
- In HALT: if_ready=0. ex_valid clears after the HLT word leaves, subject to ex_stall.
- flush in the same cycle as the HLT transfer cancels the HLT (stays RUN).

## Timing
- Reset (async assert, sync-free release): ex_valid=0, all ex_* fields 0, halted=0. if_ready follows combinationally (1 when ex_stall=0).
- Latency: if_instr accepted at edge N appears on ex_* after edge N. One instruction per cycle sustained.
- Load-use: exactly one bubble cycle, after which the dependent instruction issues.
- ex_stall and hazard together: hold; no bubble inserted.
- Reset mid-stall or mid-bubble: all state cleared immediately.

## Test plan
- Reset: rst_n=0 with garbage on inputs -> ex_valid=0, ex_A=0, halted=0. Release with if_valid=1 -> if_ready=1.
- ADD R3,R1,R2 with rf_rdata1=0x0005, rf_rdata2=0x0007 -> next cycle ex_opcode=0, ex_A=0x0005, ex_B=0x0007, ex_rd=3, ex_wr_en=1. Also rf_raddr1=1 and rf_raddr2=2 during the input cycle.
- LW R4,R2,-2 (0x842E) followed by ADD R5,R4,R1 -> LW output ex_I=0xFE, ex_mem_rd=1; then one cycle if_ready=0 / ex_valid=0; then the ADD issues.
- ex_stall held 3 cycles with SW R6,R7,3 in the register -> all ex_* fields unchanged, ex_B=R6 data, if_ready=0 throughout.
- flush asserted with LHB live and SLL on input -> next cycle ex_valid=0, SLL dropped, following instruction accepted normally.
- HLT (0xF000) accepted -> halted=1, if_ready=0 forever. A subsequent ADD is never accepted until reset.
